// File: rtl/i2c_master_multi.sv
// I2C bus master: START, 7-bit address + R/W, address ACK, 0..2^LEN_W-1 data
// bytes with valid/ready streaming, NACK abort, then STOP.
module i2c_master_multi #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic [3:0]       state,
  output logic             scl,
  output logic             sda_out,
  input  logic             sda_in
);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_ADDR      = 4'd2,
    S_ADDR_ACK  = 4'd3,
    S_WRITE     = 4'd4,
    S_WRITE_ACK = 4'd5,
    S_READ      = 4'd6,
    S_READ_ACK  = 4'd7,
    S_STOP      = 4'd8
  } state_t;

  state_t           cur, nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [LEN_W-1:0] cnt;
  logic             rw_q;
  logic             accept, load_pt, stall, tick, end_bit;

  // Load point is the first clk of P0 of bit 7; the engine freezes there until data arrives.
  assign accept  = (cur == S_IDLE) && start;
  assign load_pt = (cur == S_WRITE) && (bit_cnt == 3'd7) && (phase == 2'd0) && (div_cnt == '0);
  assign stall   = load_pt && !wr_valid;
  assign tick    = (cur != S_IDLE) && !stall && (div_cnt == DIV_MAX);
  assign end_bit = tick && (phase == 2'd3);

  assign state = cur;
  assign busy  = (cur != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) cur <= S_IDLE;
    else      cur <= nxt;
  end

  always_comb begin
    nxt     = cur;
    scl     = (phase == 2'd1) || (phase == 2'd2);
    sda_out = 1'b1;
    case (cur)
      S_IDLE: begin
        scl = 1'b1;
        if (start) nxt = S_START;
      end
      S_START: begin
        sda_out = (phase < 2'd2);
        if (end_bit) nxt = S_ADDR;
      end
      S_ADDR: begin
        sda_out = shreg[7];
        if (end_bit && bit_cnt == 3'd0) nxt = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        if (end_bit) begin
          if (nack || cnt == '0) nxt = S_STOP;
          else if (rw_q)         nxt = S_READ;
          else                   nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        sda_out = shreg[7];
        if (end_bit && bit_cnt == 3'd0) nxt = S_WRITE_ACK;
      end
      S_WRITE_ACK: begin
        if (end_bit) nxt = (nack || cnt == LEN_W'(1)) ? S_STOP : S_WRITE;
      end
      S_READ: begin
        if (end_bit && bit_cnt == 3'd0) nxt = S_READ_ACK;
      end
      S_READ_ACK: begin
        sda_out = (cnt == LEN_W'(1));
        if (end_bit) nxt = (cnt == LEN_W'(1)) ? S_STOP : S_READ;
      end
      S_STOP: begin
        sda_out = phase[1];
        scl     = (phase != 2'd0);
        if (end_bit) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt  <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cnt      <= '0;
      rw_q     <= 1'b0;
      nack     <= 1'b0;
      done     <= 1'b0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      done     <= 1'b0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      if (accept) begin
        rw_q    <= rw;
        cnt     <= len;
        shreg   <= {addr, rw};
        nack    <= 1'b0;
        div_cnt <= '0;
        phase   <= '0;
        bit_cnt <= 3'd7;
      end else if (cur != S_IDLE) begin
        if (load_pt && wr_valid) begin
          shreg    <= wr_data;
          wr_ready <= 1'b1;
        end
        if (!stall) div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);
        if (tick) phase <= phase + 2'd1;
        if (tick && phase == 2'd2) begin
          case (cur)
            S_ADDR_ACK, S_WRITE_ACK: if (sda_in) nack <= 1'b1;
            S_READ: begin
              shreg <= {shreg[6:0], sda_in};
              if (bit_cnt == 3'd0) begin
                rd_data  <= {shreg[6:0], sda_in};
                rd_valid <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (end_bit) begin
          case (cur)
            S_ADDR, S_WRITE, S_READ: begin
              bit_cnt <= (bit_cnt == 3'd0) ? 3'd7 : bit_cnt - 3'd1;
              if (cur != S_READ) shreg <= {shreg[6:0], 1'b0};
            end
            S_WRITE_ACK, S_READ_ACK: cnt <= cnt - LEN_W'(1);
            S_STOP: done <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_multi.sv
// Bench for i2c_master_multi: bus-slot level reference model with a scripted slave
// and a scheduled write-data source.
module tb_i2c_master_multi;
  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned BIT_CLKS = 4 * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             rw = 1'b0;
  logic [6:0]       addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic [7:0]       wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             sda_in = 1'b1;
  logic             wr_ready, rd_valid, busy, done, nack, scl, sda_out;
  logic [7:0]       rd_data;
  logic [3:0]       state;

  always #5 clk = ~clk;

  i2c_master_multi #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .nack(nack), .state(state), .scl(scl), .sda_out(sda_out), .sda_in(sda_in)
  );

  int unsigned passed = 0;
  int unsigned fails  = 0;
  int unsigned total  = 0;

  // transaction description consumed by run_txn
  bit       t_rw;
  bit [6:0] t_addr;
  int       t_len;
  bit [7:0] t_wb [16];
  bit [7:0] t_rb [16];
  int       t_stall [16];
  bit       t_nack_addr;
  int       t_nack_byte;
  int       t_abort_slot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input bit r, input bit [6:0] a, input int n);
    t_rw = r; t_addr = a; t_len = n;
    t_nack_addr = 1'b0; t_nack_byte = 0; t_abort_slot = 0;
    for (int i = 0; i < 16; i++) begin
      t_wb[i] = 8'($urandom);
      t_rb[i] = 8'($urandom);
      t_stall[i] = 0;
    end
  endtask

  task automatic run_txn(input string nm);
    bit         exp_sda [0:159];
    bit         resp [0:159];
    bit         obs_sda [0:159];
    bit         stall_cyc [0:4095];
    int         lk [16];
    logic [7:0] obs_rd [16];
    bit [7:0]   ab;
    int         n_eff, nslots, exp_done, acc, c, slot, nrd, nwr, wk, done_c, viol, bad_sda;
    bit         prev_scl, exp_nack, data_nack;
    logic       busy_at_done;

    // Bus slots: 0 START, 1..8 address, 9 address ACK, 9 per byte, last STOP.
    ab        = {t_addr, t_rw};
    data_nack = !t_rw && !t_nack_addr && t_nack_byte >= 1 && t_nack_byte <= t_len;
    exp_nack  = t_nack_addr || data_nack;
    n_eff     = t_nack_addr ? 0 : (data_nack ? t_nack_byte : t_len);
    nslots    = 9 * (n_eff + 1) + 2;
    for (int i = 0; i < 160; i++) begin
      exp_sda[i] = 1'b1; resp[i] = 1'b1; obs_sda[i] = 1'b0;
    end
    for (int i = 0; i < 4096; i++) stall_cyc[i] = 1'b0;
    for (int b = 0; b < 8; b++) exp_sda[1+b] = ab[7-b];
    resp[9] = t_nack_addr;
    acc = 0;
    for (int k = 1; k <= t_len; k++) begin
      int base;
      base = 10 + 9 * (k - 1);
      lk[k-1] = 1 + base * BIT_CLKS + acc;
      if (k <= n_eff) begin
        for (int b = 0; b < 8; b++) begin
          if (t_rw) resp[base+b] = t_rb[k-1][7-b];
          else      exp_sda[base+b] = t_wb[k-1][7-b];
        end
        if (t_rw) exp_sda[base+8] = (k == t_len);
        else      resp[base+8] = (k == t_nack_byte);
        if (!t_rw) begin
          for (int s = 0; s < t_stall[k-1]; s++)
            if (lk[k-1] + s < 4096) stall_cyc[lk[k-1]+s] = 1'b1;
          acc += t_stall[k-1];
        end
      end
    end
    exp_sda[nslots-1] = 1'b0;
    exp_done = 1 + nslots * BIT_CLKS + acc;

    rw = t_rw; addr = t_addr; len = LEN_W'(t_len); sda_in = 1'b1;
    wk = 1;
    wr_valid = !t_rw && t_len >= 1 && t_stall[0] == 0;
    wr_data  = t_wb[0];
    start    = 1'b1;
    prev_scl = scl;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1; slot = 0; nrd = 0; nwr = 0; done_c = 0; viol = 0; busy_at_done = 1'bx;
    chk({nm, ".busy_c1"}, busy, 1);
    chk({nm, ".nack_cleared"}, nack, 0);

    while (c < 4000) begin
      if (scl && !prev_scl) begin
        if (slot < 160) begin
          obs_sda[slot] = sda_out;
          sda_in = resp[slot];
        end
        if (t_abort_slot != 0 && slot == t_abort_slot) begin
          rst = 1'b0;
          @(posedge clk); #1;
          chk({nm, ".rst_scl"}, scl, 1);
          chk({nm, ".rst_sda"}, sda_out, 1);
          chk({nm, ".rst_busy"}, busy, 0);
          chk({nm, ".rst_state"}, state, 0);
          chk({nm, ".rst_done"}, done, 0);
          chk({nm, ".rst_rd_data"}, rd_data, 0);
          rst = 1'b1; wr_valid = 1'b0; sda_in = 1'b1; start = 1'b0;
          return;
        end
        slot++;
      end
      prev_scl = scl;
      if (c < 4096 && stall_cyc[c] && scl) viol++;
      if (wr_ready) begin nwr++; wk++; end
      if (rd_valid) begin
        if (nrd < 16) obs_rd[nrd] = rd_data;
        nrd++;
      end
      if (done) begin
        done_c = c; busy_at_done = busy;
        break;
      end
      if (c == 60) begin
        start = 1'b1; rw = ~t_rw; addr = ~t_addr; len = LEN_W'(5);
      end else begin
        start = 1'b0; rw = t_rw; addr = t_addr; len = LEN_W'(t_len);
      end
      if (!t_rw && wk <= t_len) begin
        wr_data  = t_wb[wk-1];
        wr_valid = (t_stall[wk-1] == 0) || (c >= lk[wk-1] + t_stall[wk-1]);
      end else begin
        wr_valid = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0; wr_valid = 1'b0;

    chk({nm, ".done_seen"}, done_c != 0, 1);
    chk({nm, ".done_cycle"}, done_c, exp_done);
    chk({nm, ".busy_at_done"}, busy_at_done, 0);
    chk({nm, ".scl_rises"}, slot, nslots);
    bad_sda = 0;
    for (int i = 0; i < nslots && i < 160; i++) if (obs_sda[i] !== exp_sda[i]) bad_sda++;
    chk({nm, ".sda_bits_wrong"}, bad_sda, 0);
    chk({nm, ".wr_ready_count"}, nwr, t_rw ? 0 : n_eff);
    chk({nm, ".rd_valid_count"}, nrd, t_rw ? n_eff : 0);
    for (int k = 0; k < n_eff && k < nrd && k < 16; k++)
      if (t_rw) chk({nm, $sformatf(".rd_byte%0d", k)}, obs_rd[k], t_rb[k]);
    chk({nm, ".nack"}, nack, exp_nack);
    chk({nm, ".scl_high_in_stall"}, viol, 0);
    @(posedge clk); #1;
    chk({nm, ".done_one_cycle"}, done, 0);
    chk({nm, ".idle_scl"}, scl, 1);
    chk({nm, ".idle_sda"}, sda_out, 1);
    sda_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({nm, ".nack_sticky"}, nack, exp_nack);
    chk({nm, ".idle_state"}, state, 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.scl", scl, 1);
    chk("reset.sda", sda_out, 1);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.nack", nack, 0);
    chk("reset.wr_ready", wr_ready, 0);
    chk("reset.rd_valid", rd_valid, 0);
    chk("reset.rd_data", rd_data, 0);
    chk("reset.state", state, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    setup(1'b0, 7'h5a, 1); t_wb[0] = 8'hA5;
    run_txn("write1");

    setup(1'b1, 7'h5a, 2); t_rb[0] = 8'h3C; t_rb[1] = 8'hC3;
    run_txn("read2");

    setup(1'b0, 7'h5a, 3); t_nack_addr = 1'b1;
    run_txn("addr_nack");

    setup(1'b0, 7'h5a, 2); t_stall[1] = 20;
    run_txn("stall20");

    setup(1'b0, 7'h5a, 2); t_abort_slot = 13;
    run_txn("rst_mid");

    rst = 1'b0; start = 1'b1; rw = 1'b0; addr = 7'h22; len = LEN_W'(1);
    @(posedge clk); #1;
    chk("rst_vs_start.busy", busy, 0);
    chk("rst_vs_start.state", state, 0);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_vs_start.still_idle", busy, 0);

    setup(1'b0, 7'h10, 0);
    run_txn("probe");

    setup(1'b1, 7'($urandom), 15);
    run_txn("read_max");

    setup(1'b0, 7'($urandom), 4); t_nack_byte = 2; t_stall[0] = 3;
    run_txn("data_nack");

    for (int n = 0; n < 5; n++) begin
      bit r;
      int l;
      r = 1'($urandom_range(0, 1));
      l = int'($urandom_range(0, 15));
      setup(r, 7'($urandom), l);
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 3) == 0) t_stall[i] = int'($urandom_range(1, 20));
      if ($urandom_range(0, 4) == 0) t_nack_addr = 1'b1;
      else if (!r && l > 0 && $urandom_range(0, 3) == 0) t_nack_byte = int'($urandom_range(1, l));
      run_txn($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
